piso_shreg: RTL and testbench

Parallel-in, serial-out shift stage that sits directly downstream of the 4-bit parallel-load register. It accepts one parallel word through a valid/ready load handshake and emits it one bit per accepted beat on a serial output that supports backpressure. It flags the final bit of each word and optionally appends an even-parity bit.

---
 rtl/piso_shreg.sv | 133 +++++++++++++
 tb/tb_piso_shreg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-in, serial-out shift stage with valid/ready on both sides.
// A word is loaded in IDLE, then shifted out one bit per accepted beat.
// sout_last flags the final bit of each frame.
// Optional feature macro: PARITY_EN appends an even-parity bit to every frame.
// With PARITY_EN the last-bit flag moves from the final data bit to the parity bit.
// All outputs are decoded from registered state only.
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inp,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam int               OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             last_data;

  assign load      = (state == IDLE) && load_valid;
  assign last_data = (cnt == CNT_LAST);

`ifdef PARITY_EN
  logic parity;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Capture the parity of the word at load time; it is emitted after the data bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    parity <= 1'b0;
    else if (load) parity <= even_parity(inp);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: advance only on accepted beats, leave data state on the last bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (sout_ready && last_data) begin
`ifdef PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end
      end
      PARITY: begin
        if (sout_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register and bit counter: load in IDLE, shift on each accepted data beat.
  // The counter saturates at the last index so it never leaves 0..WIDTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= inp;
      cnt   <= '0;
    end else if ((state == SHIFT) && sout_ready) begin
      if (MSB_FIRST) shreg <= shreg << 1;
      else           shreg <= shreg >> 1;
      if (!last_data) cnt <= cnt + 1'b1;
    end
  end

  // Moore output decode from state, shift register and counter.
  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = shreg[OUT_IDX];
`ifdef PARITY_EN
        sout_last  = 1'b0;
`else
        sout_last  = last_data;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        sout_valid = 1'b1;
        sout       = parity;
        sout_last  = 1'b1;
      end
`endif
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shreg.sv
// Testbench for piso_shreg: one MSB-first and one LSB-first instance share the same stimulus.
// A queue-based reference model is compared against both instances every cycle.
// Directed vectors and hand-written sequences check frame contents, stalls, ignored loads
// and reset.
// Honours PARITY_EN when it is defined for the whole build.
module tb_piso_shreg;

  localparam int WIDTH = 4;
`ifdef PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] inp = '0;
  logic             load_valid = 1'b0;
  logic             sout_ready = 1'b0;

  logic m_load_ready, m_sout, m_sout_valid, m_sout_last;
  logic l_load_ready, l_sout, l_sout_valid, l_sout_last;

  piso_shreg #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .inp        (inp),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .sout       (m_sout),
    .sout_valid (m_sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (m_sout_last)
  );

  piso_shreg #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .inp        (inp),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .sout       (l_sout),
    .sout_valid (l_sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (l_sout_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the bits still to be emitted for the current frame, oldest first.
  logic qm[$];
  logic ql[$];

  // Values seen at the most recent sample point.
  logic cap_m, cap_l, cap_v, cap_rdy;

  typedef struct {
    logic [3:0] inp;
    logic [3:0] seq_m;
    logic [3:0] seq_l;
    logic       par;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic e_valid, e_m, e_l, e_last;
    e_valid = (qm.size() != 0);
    e_m     = e_valid ? qm[0] : 1'b0;
    e_l     = e_valid ? ql[0] : 1'b0;
    e_last  = (qm.size() == 1);
    chk("msb_load_ready", m_load_ready, !e_valid);
    chk("msb_sout_valid", m_sout_valid, e_valid);
    chk("msb_sout",       m_sout,       e_m);
    chk("msb_sout_last",  m_sout_last,  e_last);
    chk("lsb_load_ready", l_load_ready, !e_valid);
    chk("lsb_sout_valid", l_sout_valid, e_valid);
    chk("lsb_sout",       l_sout,       e_l);
    chk("lsb_sout_last",  l_sout_last,  e_last);
  endtask

  task automatic model_update();
    if (!reset) begin
      qm.delete();
      ql.delete();
    end else if (qm.size() == 0) begin
      if (load_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          qm.push_back(inp[WIDTH-1-i]);
          ql.push_back(inp[i]);
        end
`ifdef PARITY_EN
        qm.push_back(^inp);
        ql.push_back(^inp);
`endif
      end
    end else if (sout_ready) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
  endtask

  // One clock: sample and check on the falling edge, update the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    cap_m   = m_sout;
    cap_l   = l_sout;
    cap_v   = m_sout_valid;
    cap_rdy = m_load_ready;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    load_valid = 1'b0;
    sout_ready = 1'b1;
    for (int k = 0; k < 4 * FL && qm.size() != 0; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] sm, sl;
    int nb;

    vecs[0] = '{4'b1100, 4'b1100, 4'b0011, 1'b0};
    vecs[1] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};
    vecs[2] = '{4'b0100, 4'b0100, 4'b0010, 1'b1};
    vecs[3] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
    vecs[4] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
    vecs[5] = '{4'b1010, 4'b1010, 4'b0101, 1'b0};

    // Reset from power-up: outputs go to their idle values without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("por_load_ready", m_load_ready, 1'b1);
    chk("por_sout_valid", m_sout_valid, 1'b0);
    chk("por_sout",       m_sout,       1'b0);
    chk("por_sout_last",  m_sout_last,  1'b0);
    load_valid = 1'b1;
    inp = 4'b1111;
    tick();
    tick();
    reset = 1'b1;
    inp = 4'b1100;
    tick();
    load_valid = 1'b0;
    sout_ready = 1'b1;
    tick();
    chk("first_bit_after_reset_valid", cap_v, 1'b1);
    chk("first_bit_after_reset_sout",  cap_m, 1'b1);
    drain();

    // Directed vectors, sout_ready held high.
    for (int v = 0; v < 6; v++) begin
      drain();
      inp = vecs[v].inp;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      sm = '0;
      sl = '0;
      for (int i = 0; i < WIDTH; i++) begin
        tick();
        sm = {sm[2:0], cap_m};
        sl = {sl[2:0], cap_l};
      end
      chk("vec_seq_msb", sm, vecs[v].seq_m);
      chk("vec_seq_lsb", sl, vecs[v].seq_l);
`ifdef PARITY_EN
      tick();
      chk("vec_parity", cap_m, vecs[v].par);
`endif
      tick();
      chk("vec_ready_after_frame", cap_rdy, 1'b1);
    end

    // Backpressure: LSB-first 1000, three stall cycles after the second bit.
    drain();
    inp = 4'b1000;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    sl = '0;
    nb = 0;
    for (int c = 0; c < 7; c++) begin
      sout_ready = !(c >= 2 && c <= 4);
      tick();
      if (cap_v && sout_ready) begin
        sl = {sl[2:0], cap_l};
        nb++;
      end
      if (c >= 2 && c <= 4) begin
        chk("stall_valid", cap_v, 1'b1);
        chk("stall_sout",  cap_l, 1'b0);
      end
    end
    chk("stall_seq_lsb", sl, 4'b0001);
    chk("stall_beats", 8'(nb), 8'd4);
    drain();

    // Load attempt while busy is ignored.
    inp = 4'b1100;
    load_valid = 1'b1;
    tick();
    inp = 4'b1111;
    sm = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_valid = (i < 2);
      tick();
      sm = {sm[2:0], cap_m};
    end
    chk("busy_seq_msb", sm, 4'b1100);
    drain();

    // Reset mid-frame after two bits, then a clean frame.
    inp = 4'b1010;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    qm.delete();
    ql.delete();
    #1;
    chk("midrst_sout_valid", m_sout_valid, 1'b0);
    chk("midrst_load_ready", m_load_ready, 1'b1);
    chk("midrst_sout",       m_sout,       1'b0);
    chk("midrst_sout_last",  l_sout_last,  1'b0);
    load_valid = 1'b1;
    inp = 4'b1111;
    tick();
    reset = 1'b1;
    inp = 4'b0110;
    tick();
    load_valid = 1'b0;
    sm = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      sm = {sm[2:0], cap_m};
    end
    chk("post_rst_seq_msb", sm, 4'b0110);
    drain();

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int n = 0; n < 400; n++) begin
      load_valid = 1'($urandom_range(0, 1));
      sout_ready = ($urandom_range(0, 3) != 0);
      inp = 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        qm.delete();
        ql.delete();
      end else begin
        reset = 1'b1;
      end
      tick();
    end
    reset = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
